// File: rtl/axi_request_arbiter_if.sv
// axi_request_arbiter_if: requester-side and sub-unit-side signals of the request arbiter
interface axi_request_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req_valid, req_re, req_we, req_ack, req_done, rsp_valid;
  logic [NUM_REQ*32-1:0] req_addr, req_data;
  logic [NUM_REQ*4-1:0] req_be;
  logic [NUM_REQ*3-1:0] req_size;
  logic [31:0] rsp_data, ds_addr, ds_data_in, ds_data_out;
  logic ds_new_request, ds_re, ds_we, ds_ready, ds_data_valid;
  logic [3:0] ds_be;
  logic [2:0] ds_size;
  modport slave (
    input req_valid, req_re, req_we, req_addr, req_data, req_be, req_size, ds_ready, ds_data_valid, ds_data_out,
    output req_ack, req_done, rsp_valid, rsp_data, ds_new_request, ds_re, ds_we, ds_addr, ds_data_in, ds_be, ds_size
  );
  modport master (
    output req_valid, req_re, req_we, req_addr, req_data, req_be, req_size, ds_ready, ds_data_valid, ds_data_out,
    input req_ack, req_done, rsp_valid, rsp_data, ds_new_request, ds_re, ds_we, ds_addr, ds_data_in, ds_be, ds_size
  );
endinterface

// File: rtl/axi_request_arbiter.sv
// axi_request_arbiter: round-robin sharing of one single-outstanding AXI sub-unit among NUM_REQ requesters
module axi_request_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = NUM_REQ > 2 ? $clog2(NUM_REQ) : 1
) (
  input logic clk,
  input logic rst,
  axi_request_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [IDX_W-1:0] owner, rr_ptr, winner;
  logic found, grant;
  int idx;
  // scanning from the far end lets the nearest valid index after rr_ptr overwrite the rest
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end
  always_comb begin
    grant = state == IDLE && bus.ds_ready && found;
    bus.req_ack = grant ? NUM_REQ'(1) << winner : '0;
    bus.req_done = state == WAIT && bus.ds_ready ? NUM_REQ'(1) << owner : '0;
    bus.rsp_valid = state == WAIT && bus.ds_data_valid ? NUM_REQ'(1) << owner : '0;
    bus.rsp_data = bus.ds_data_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.ds_new_request <= 1'b0;
      bus.ds_re <= 1'b0;
      bus.ds_we <= 1'b0;
      owner <= '0;
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (grant) begin
          state <= ISSUE;
          bus.ds_new_request <= 1'b1;
          bus.ds_re <= bus.req_re[winner];
          bus.ds_we <= bus.req_we[winner];
          owner <= winner;
          rr_ptr <= winner;
        end
        ISSUE: begin
          state <= WAIT;
          bus.ds_new_request <= 1'b0;
        end
        WAIT: if (bus.ds_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // payload registers carry no reset; they are only meaningful alongside ds_new_request
  always_ff @(posedge clk) begin
    if (grant) begin
      bus.ds_addr <= bus.req_addr[32*winner +: 32];
      bus.ds_data_in <= bus.req_data[32*winner +: 32];
      bus.ds_be <= bus.req_be[4*winner +: 4];
      bus.ds_size <= bus.req_size[3*winner +: 3];
    end
  end
endmodule

// File: tb/tb_axi_request_arbiter.sv
// tb_axi_request_arbiter: transaction-level model check plus directed scenarios for the request arbiter
module tb_axi_request_arbiter;
  localparam int N = 3;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  axi_request_arbiter_if #(.NUM_REQ(N)) bus();
  axi_request_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // transaction-level model: one outstanding job, issue cycle, then wait for sub-unit completion
  bit armed = 0, m_busy, m_issue;
  int m_owner, m_last;
  logic m_re, m_we;
  logic [31:0] m_addr, m_data;
  logic [3:0] m_be;
  logic [2:0] m_size;
  logic [N-1:0] ack_log[$];

  initial forever begin
    int w;
    logic [N-1:0] e_ack, e_done, e_rsp;
    @(negedge clk);
    w = -1;
    if (armed) begin
      e_ack = '0; e_done = '0; e_rsp = '0;
      if (!m_busy && bus.ds_ready) w = pick(bus.req_valid, m_last);
      if (w >= 0) e_ack[w] = 1'b1;
      if (m_busy && !m_issue) begin
        if (bus.ds_data_valid) e_rsp[m_owner] = 1'b1;
        if (bus.ds_ready) e_done[m_owner] = 1'b1;
      end
      chk("m_ack", 32'(bus.req_ack), 32'(e_ack));
      chk("m_done", 32'(bus.req_done), 32'(e_done));
      chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
      chk("m_rsp_data", bus.rsp_data, bus.ds_data_out);
      chk("m_new_req", 32'(bus.ds_new_request), 32'(m_issue));
      chk("m_re_we", {30'd0, bus.ds_re, bus.ds_we}, {30'd0, m_re, m_we});
      if (m_issue) begin
        chk("m_addr", bus.ds_addr, m_addr);
        chk("m_wdata", bus.ds_data_in, m_data);
        chk("m_be_size", {25'd0, bus.ds_be, bus.ds_size}, {25'd0, m_be, m_size});
      end
    end
    if (bus.req_ack != '0) ack_log.push_back(bus.req_ack);
    if (rst) begin
      m_busy = 0; m_issue = 0; m_owner = 0; m_last = N - 1; m_re = 0; m_we = 0; armed = 1;
    end else if (armed) begin
      if (m_issue) m_issue = 0;
      else if (m_busy) begin
        if (bus.ds_ready) m_busy = 0;
      end else if (w >= 0) begin
        m_busy = 1; m_issue = 1; m_owner = w; m_last = w;
        m_re = bus.req_re[w]; m_we = bus.req_we[w];
        m_addr = bus.req_addr[32*w +: 32]; m_data = bus.req_data[32*w +: 32];
        m_be = bus.req_be[4*w +: 4]; m_size = bus.req_size[3*w +: 3];
      end
    end
  end

  int su_cnt = 0;
  logic su_rd = 0;
  // randomized sub-unit: drops ready during issue, completes 2..5 cycles later
  task automatic su_step();
    bus.ds_data_out = $urandom;
    bus.ds_data_valid = 1'b0;
    if (rst) begin
      su_cnt = 0; bus.ds_ready = 1'b1;
    end else if (bus.ds_new_request) begin
      su_cnt = $urandom_range(2, 5); su_rd = bus.ds_re; bus.ds_ready = 1'b0;
    end else if (su_cnt > 0) begin
      su_cnt--;
      bus.ds_ready = su_cnt == 0;
      bus.ds_data_valid = su_rd && (su_cnt == 0 || $urandom_range(0, 3) == 0);
    end else begin
      bus.ds_ready = $urandom_range(0, 4) != 0;
      bus.ds_data_valid = $urandom_range(0, 5) == 0;
    end
  endtask

  task automatic req_step(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && (a[i] || $urandom_range(0, 15) == 0)) bus.req_valid[i] = 1'b0;
      else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
        logic w = 1'($urandom_range(0, 1));
        bus.req_valid[i] = 1'b1; bus.req_re[i] = !w; bus.req_we[i] = w;
        bus.req_addr[32*i +: 32] = $urandom; bus.req_data[32*i +: 32] = $urandom;
        bus.req_be[4*i +: 4] = 4'($urandom); bus.req_size[3*i +: 3] = 3'($urandom_range(0, 2));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_one(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
    tick();
    bus.req_valid = '0; bus.req_valid[i] = 1'b1; bus.req_re[i] = !w; bus.req_we[i] = w;
    bus.req_addr[32*i +: 32] = a; bus.req_data[32*i +: 32] = d; bus.req_be[4*i +: 4] = 4'hF; bus.req_size[3*i +: 3] = 3'd2;
    @(negedge clk); chk("one_ack", 32'(bus.req_ack), 32'(1) << i);
    tick(); bus.req_valid = '0; bus.ds_ready = 1'b0;
    @(negedge clk);
    chk("one_issue", 32'(bus.ds_new_request), 32'd1);
    chk("one_addr", bus.ds_addr, a);
    chk("one_dir", {30'd0, bus.ds_re, bus.ds_we}, {30'd0, !w, w});
    if (w) chk("one_wdata", bus.ds_data_in, d);
    chk("one_be", 32'(bus.ds_be), 32'hF);
    tick();
    @(negedge clk);
    chk("one_issue_gone", 32'(bus.ds_new_request), 32'd0);
    chk("one_wait_done", 32'(bus.req_done), 32'd0);
    tick(); bus.ds_ready = 1'b1; bus.ds_data_valid = !w; bus.ds_data_out = rd;
    @(negedge clk);
    chk("one_done", 32'(bus.req_done), 32'(1) << i);
    chk("one_rsp_valid", 32'(bus.rsp_valid), w ? 32'd0 : 32'(1) << i);
    if (!w) chk("one_rsp_data", bus.rsp_data, rd);
    tick(); bus.ds_data_valid = 1'b0;
    @(negedge clk); chk("one_idle_done", 32'(bus.req_done), 32'd0);
  endtask

  task automatic finish_txn();
    tick(); bus.req_valid = '0; bus.ds_ready = 1'b0;
    tick(); bus.ds_ready = 1'b1;
    tick();
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] order[6];
    bus.req_valid = '0; bus.req_re = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.req_be = '0; bus.req_size = '0; bus.ds_ready = 1'b1; bus.ds_data_valid = 1'b0; bus.ds_data_out = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ack", 32'(bus.req_ack), 32'd0);
    chk("rst_new_req", 32'(bus.ds_new_request), 32'd0);
    chk("rst_re_we", {30'd0, bus.ds_re, bus.ds_we}, 32'd0);
    chk("rst_done_rsp", {bus.req_done, bus.rsp_valid}, 32'd0);

    run_one(0, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF);
    run_one(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0);

    tick(); bus.ds_ready = 1'b0; bus.req_valid = 3'b001; bus.req_re = 3'b111; bus.req_we = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("blk_ack", 32'(bus.req_ack), 32'd0);
      chk("blk_new_req", 32'(bus.ds_new_request), 32'd0);
      tick();
    end
    bus.ds_ready = 1'b1;
    @(negedge clk); chk("blk_release_ack", 32'(bus.req_ack), 32'd1);
    finish_txn();

    bus.ds_ready = 1'b0; bus.req_valid = 3'b010; bus.ds_data_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("spur_ack", 32'(bus.req_ack), 32'd0);
      chk("spur_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.req_valid = '0; bus.ds_ready = 1'b1;
    @(negedge clk);
    chk("drop_ack", 32'(bus.req_ack), 32'd0);
    chk("drop_rsp", 32'(bus.rsp_valid), 32'd0);
    tick(); bus.ds_data_valid = 1'b0; bus.req_valid = 3'b010;
    @(negedge clk); chk("rw_ack", 32'(bus.req_ack), 32'b010);
    tick(); bus.req_valid = '0; bus.ds_ready = 1'b0;
    tick();
    tick(); rst = 1;
    @(negedge clk); chk("rw_rst_done", 32'(bus.req_done), 32'd0);
    tick(); rst = 0; bus.ds_ready = 1'b1; bus.req_valid = 3'b111;
    @(negedge clk);
    chk("rw_post_done", 32'(bus.req_done), 32'd0);
    chk("rw_post_new_req", 32'(bus.ds_new_request), 32'd0);
    chk("rw_post_ack", 32'(bus.req_ack), 32'b001);
    finish_txn();

    tick(); rst = 1; bus.req_valid = 3'b111; bus.req_re = 3'b111; bus.req_we = '0; su_step();
    tick(); rst = 0; ack_log.delete(); su_step();
    for (int c = 0; c < 300 && ack_log.size() < 6; c++) begin
      tick(); su_step();
    end
    chk("rr_count", ack_log.size(), 6);
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 6 && k < ack_log.size(); k++) chk("rr_order", 32'(ack_log[k]), 32'(order[k]));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); a = bus.req_ack;
      tick();
      rst = $urandom_range(0, 199) == 0;
      su_step();
      req_step(a);
    end
    tick(); rst = 0; bus.req_valid = '0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_request_arbiter.md
Name: axi_request_arbiter

Overview:
- Shares one single-outstanding AXI master sub-unit between NUM_REQ load/store requesters, e.g. data port, page-table walker and debug port.
- Sits between the requesters and the downstream sub-unit's request/response signals.
- Grants round-robin, issues exactly one transaction at a time, and routes read data and completion back to the owning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ) (min 1), width of owner/pointer registers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  requester i has a pending transaction; held until req_ack[i]
- req_re  in  NUM_REQ  read request
- req_we  in  NUM_REQ  write request; exactly one of re/we high when valid
- req_addr  in  NUM_REQ*32  byte address, slice i
- req_data  in  NUM_REQ*32  write data, slice i
- req_be  in  NUM_REQ*4  byte enables, slice i
- req_size  in  NUM_REQ*3  AXI size, slice i
- req_ack  out  NUM_REQ  one-cycle acceptance pulse, one-hot or zero
- req_done  out  NUM_REQ  one-cycle completion pulse to owner (reads and writes)
- rsp_valid  out  NUM_REQ  read data valid for owner
- rsp_data  out  32  read data, shared by all requesters
- ds_new_request  out  1  registered one-cycle issue pulse to sub-unit
- ds_re, ds_we  out  1 each  registered copies of winner's re/we
- ds_addr  out  32  registered copy of winner's address
- ds_data_in  out  32  registered copy of winner's write data
- ds_be  out  4  registered copy of winner's byte enables
- ds_size  out  3  registered copy of winner's size
- ds_ready  in  1  sub-unit idle; must be low by the cycle after ds_new_request
- ds_data_valid  in  1  sub-unit read data valid
- ds_data_out  in  32  sub-unit read data

Behaviour:
- Reset:
  - state=IDLE, ds_new_request=0, ds_re=0, ds_we=0, owner=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - ds_addr/ds_data_in/ds_be/ds_size are not reset.
  - All combinational outputs evaluate to 0 in IDLE with no requests.
- Reset mid-transaction abandons the transaction; the sub-unit shares rst and also resets.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If ds_ready=1 and any req_valid, winner = first valid index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Same cycle: req_ack[winner]=1 (combinational), capture winner's fields into ds_* registers, owner<=winner, rr_ptr<=winner, ds_new_request<=1, go ISSUE.
  - If ds_ready=0 or no valid requests, stay in IDLE with no ack.
- ISSUE: lasts exactly one cycle with ds_new_request=1. ds_ready is ignored. Next cycle: ds_new_request<=0, go WAIT.
- WAIT:
  - rsp_valid[owner] = ds_data_valid (combinational), and only in WAIT.
  - rsp_data = ds_data_out at all times.
  - When ds_ready=1: req_done[owner]=1 for that cycle, go IDLE.
  - ds_data_valid and ds_ready may rise in the same cycle; both rsp_valid and req_done pulse together.
- Latency and throughput:
  - Minimum turnaround is ack at cycle t, ds_new_request at t+1, then sub-unit latency.
  - At most one transaction is outstanding; a new grant is possible in the cycle after req_done.
  - In the done cycle itself the FSM is still WAIT, so no ack is given.
- Fairness: a continuously valid requester is granted at least once every NUM_REQ grants.
- Requests dropped before ack are legal: the scan uses current req_valid only.
- ds_data_valid outside WAIT is ignored and produces no rsp_valid.
- ds_re and ds_we are held until the next grant; they have no meaning outside ISSUE.
- rr_ptr wraps from NUM_REQ-1 to 0. Non-power-of-2 NUM_REQ must wrap correctly, with no out-of-range index.

Test Plan:
- Single read: req_valid=01, re, addr=0x8000_0010, sub-unit returns 0xDEADBEEF -> ack[0] at t, ds_new_request at t+1 only, rsp_valid=01 and rsp_data=0xDEADBEEF in the same cycle as done[0], back to IDLE.
- Single write: req1 we, addr=0x100, data=0x12345678, be=0xF -> ds_addr/ds_data_in/ds_be match at t+1, done[1] pulses, rsp_valid never asserts.
- Contention, NUM_REQ=3, all valid continuously from reset -> grant order 0,1,2,0,1,2; each ack is one-hot.
- Grant blocked while ds_ready=0 in IDLE, req0 valid for 5 cycles -> no ack, no ds_new_request; ack follows in the cycle ds_ready returns to 1.
- Reset in WAIT -> next cycle state IDLE, ds_new_request=0, no done pulse, requester 0 granted first afterwards.
- Spurious ds_data_valid in IDLE, plus a requester dropping valid before ack -> rsp_valid stays 0 and that requester receives no ack.
